ram8_write_sequencer: RTL and testbench



---
 rtl/ram8_write_sequencer.sv | 127 ++++++++++++
 tb/tb_ram8_write_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_write_sequencer.sv
// ram8_write_sequencer: queues {addr, data} write requests in a small circular FIFO and
// issues one per cycle as a registered load strobe, select and data bus for the RAM8
// load demultiplexer and register bank. `hold` stalls issue for the cycle it is high.
//
// Optional feature: define RAM8_WSEQ_COALESCE_EN to merge a request into the tail entry
// when its address matches (the data is overwritten and no new entry is allocated).
module ram8_write_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_addr,
  input  logic [WIDTH-1:0]         req_data,
  input  logic                     hold,
  output logic                     load,
  output logic [2:0]               sel,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Issue state, decoded from the registered count and the live hold input.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [2:0]       fifo_addr [DEPTH];
  logic [WIDTH-1:0] fifo_data [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state;
  logic          full;
  logic          pop;
  logic          alloc;

`ifdef RAM8_WSEQ_COALESCE_EN
  logic [AW-1:0] tail;
  logic          coalesce;
`endif

  // Classify the current cycle; a pop happens only in ISSUE.
  always_comb begin
    state = IDLE;
    if (count_q != '0) begin
      state = hold ? STALL : ISSUE;
    end
  end

  assign pop  = (state == ISSUE);
  assign full = (count_q == CW'(DEPTH));

`ifdef RAM8_WSEQ_COALESCE_EN
  assign tail = wr_ptr_q - AW'(1);
  // With a single entry being popped this edge the tail is leaving, so allocate instead.
  assign coalesce = (count_q != '0) && (fifo_addr[tail] == req_addr) &&
                    !(pop && (count_q == CW'(1)));
  assign req_ready = !full || coalesce;
  assign alloc     = req_valid && req_ready && !coalesce;
`else
  assign req_ready = !full;
  assign alloc     = req_valid && req_ready;
`endif

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (alloc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({alloc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents are meaningless once count drops, so no reset is needed.
  always_ff @(posedge clk) begin
    if (alloc) begin
      fifo_addr[wr_ptr_q] <= req_addr;
      fifo_data[wr_ptr_q] <= req_data;
    end
`ifdef RAM8_WSEQ_COALESCE_EN
    else if (req_valid && coalesce) begin
      fifo_data[tail] <= req_data;
    end
`endif
  end

  // Control state and the registered issue port; sel/data_out hold when nothing pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      load     <= 1'b0;
      sel      <= '0;
      data_out <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      load     <= pop;
      if (pop) begin
        sel      <= fifo_addr[rd_ptr_q];
        data_out <= fifo_data[rd_ptr_q];
      end
    end
  end

  assign count = count_q;
  assign busy  = (count_q != '0) || load;

endmodule

// File: tb/tb_ram8_write_sequencer.sv
// Scoreboard bench for ram8_write_sequencer: accepted requests push the expected strobe
// into a queue; a monitor pops and compares on every observed load strobe.
module tb_ram8_write_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_addr;
  logic [WIDTH-1:0] req_data;
  logic             hold;
  logic             load;
  logic [2:0]       sel;
  logic [WIDTH-1:0] data_out;
  logic [2:0]       count;
  logic             busy;

  typedef struct packed {
    logic [2:0]       addr;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  ram8_write_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .hold      (hold),
    .load      (load),
    .sel       (sel),
    .data_out  (data_out),
    .count     (count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && load) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected: got sel=%0d data=0x%0h expected no strobe",
                   sel, data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (sel !== e.addr || data_out !== e.data) begin
            failures++;
            $display("FAIL strobe_order: got sel=%0d data=0x%0h expected sel=%0d data=0x%0h",
                     sel, data_out, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted; optionally record the strobe it should produce.
  task automatic push(input logic [2:0] a, input logic [WIDTH-1:0] d, input bit expect_it);
    int n;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!req_ready) begin
      failures++;
      $display("FAIL push_timeout: got req_ready=0 expected 1 within 50 cycles");
    end else begin
      @(posedge clk);
      if (expect_it) exp_q.push_back('{addr: a, data: d});
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((count != 0 || load) && n < budget) begin
      cyc();
      n++;
    end
    check("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    hold      = 1'b0;

    // Reset state.
    #2;
    check("rst_load", 32'(load), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic issue: accepted at edge t, strobe visible between t+1 and t+2.
    push(3'd5, 16'h1234, 1'b1);
    check("basic_count_after_push", 32'(count), 32'd1);
    check("basic_no_load_yet", 32'(load), 32'd0);
    cyc();
    check("basic_load", 32'(load), 32'd1);
    check("basic_sel", 32'(sel), 32'd5);
    check("basic_data", 32'(data_out), 32'h1234);
    cyc();
    check("basic_load_off", 32'(load), 32'd0);
    check("basic_busy_off", 32'(busy), 32'd0);
    check("basic_sel_kept", 32'(sel), 32'd5);

    // Fill under hold, refuse a fifth, then drain in order.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(3'(i), 16'h0100 + 16'(i), 1'b1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_ready", 32'(req_ready), 32'd0);
    check("fill_busy", 32'(busy), 32'd1);
    req_valid = 1'b1;
    req_addr  = 3'd4;
    req_data  = 16'hDEAD;
    cyc();
    req_valid = 1'b0;
    check("fifth_refused_count", 32'(count), 32'd4);
    check("fill_no_load", 32'(load), 32'd0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("drain_load", 32'(load), 32'd1);
      check("drain_sel", 32'(sel), 32'(i));
    end
    cyc();
    check("drain_load_off", 32'(load), 32'd0);
    check("drain_ready", 32'(req_ready), 32'd1);

    // Back-to-back stream: one in, one out, pointers wrap.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr  = 3'((i * 3) % 8);
      req_data  = 16'h2000 + 16'(i);
      @(posedge clk);
      exp_q.push_back('{addr: 3'((i * 3) % 8), data: 16'h2000 + 16'(i)});
      #1;
      check("stream_count", 32'(count), 32'd1);
      check("stream_load", 32'(load), (i == 0) ? 32'd0 : 32'd1);
    end
    req_valid = 1'b0;
    drain(10);

    // Two-cycle hold pulse mid-stream: strobe drops for exactly two cycles, outputs frozen.
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr  = 3'(7 - i);
      req_data  = 16'h3000 + 16'(i);
      hold      = (i == 2 || i == 3);
      @(posedge clk);
      exp_q.push_back('{addr: 3'(7 - i), data: 16'h3000 + 16'(i)});
      #1;
      check("hold_load", 32'(load), (i == 2 || i == 3) ? 32'd0 : 32'd1 & 32'(i != 0));
      if (i == 2 || i == 3) begin
        check("hold_sel_frozen", 32'(sel), 32'd7);
        check("hold_data_frozen", 32'(data_out), 32'h3000);
      end
    end
    req_valid = 1'b0;
    hold      = 1'b0;
    check("hold_count_peak", 32'(count), 32'd3);
    drain(10);
    check("hold_all_issued", 32'(exp_q.size()), 32'd0);

    // Reset while a strobe is in flight with three entries still queued.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(3'(4 + i), 16'h4000 + 16'(i), 1'b1);
    hold = 1'b0;
    cyc();
    check("pre_rst_load", 32'(load), 32'd1);
    check("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_rst_load", 32'(load), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("post_rst_no_strobe", 32'(load), 32'd0);
    end

`ifdef RAM8_WSEQ_COALESCE_EN
    // Same-address requests merge into the tail entry.
    hold = 1'b1;
    push(3'd2, 16'hAAAA, 1'b0);
    push(3'd2, 16'hBBBB, 1'b0);
    check("coalesce_count", 32'(count), 32'd1);
    exp_q.push_back('{addr: 3'd2, data: 16'hBBBB});
    hold = 1'b0;
    cyc();
    check("coalesce_load", 32'(load), 32'd1);
    check("coalesce_data", 32'(data_out), 32'hBBBB);
    cyc();
    check("coalesce_single", 32'(load), 32'd0);
`endif

    cyc();
    cyc();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
